cam_route_loader: RTL and testbench

- Write-side controller for the TCAM routing table (SFLA40_16X8BW16 behind the Mem lookup block).
- Accepts route entries (source PacketID, destination ID, source-ID mask) over a valid/ready stream and sequences them into consecutive CAM addresses using the macro's write protocol.
- Drives the CS/FLUSH/VBE/DCS/WR/VBI/Data_In/Mask_In/CBE/Addr_In pins that Mem exposes during table initialisation; lookups are blocked while busy is high.

---
 rtl/cam_route_loader_if.sv | 42 ++++
 rtl/cam_route_loader.sv | 147 ++++++++++++++
 tb/tb_cam_route_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_route_loader_if.sv
// cam_route_loader_if: entry stream, session control and TCAM write-port bundle.
// master drives entries and start; slave is the loader that drives the CAM pins.
interface cam_route_loader_if #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int Bits        = 8,
    parameter int BankSize    = 1
);
    logic                   start;
    logic                   entry_valid;
    logic                   entry_ready;
    logic [ID_Width-1:0]    entry_src_id;
    logic [ID_Width-1:0]    entry_src_mask;
    logic [ID_Width-1:0]    entry_dst_id;
    logic                   entry_last;
    logic                   CS;
    logic                   FLUSH;
    logic                   VBE;
    logic                   DCS;
    logic                   WR;
    logic                   VBI;
    logic [Bits-1:0]        Data_In;
    logic [Bits-1:0]        Mask_In;
    logic [BankSize-1:0]    CBE;
    logic [AddressSize-1:0] Addr_In;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [AddressSize:0]   count;

    modport master (
        output start, entry_valid, entry_src_id, entry_src_mask, entry_dst_id, entry_last,
        input  entry_ready, CS, FLUSH, VBE, DCS, WR, VBI, Data_In, Mask_In, CBE, Addr_In,
               busy, done, overflow, count
    );

    modport slave (
        input  start, entry_valid, entry_src_id, entry_src_mask, entry_dst_id, entry_last,
        output entry_ready, CS, FLUSH, VBE, DCS, WR, VBI, Data_In, Mask_In, CBE, Addr_In,
               busy, done, overflow, count
    );
endinterface

// File: rtl/cam_route_loader.sv
// cam_route_loader: streams route entries into consecutive TCAM addresses using the macro write protocol.
// Define ROUTE_LOADER_FLUSH_EN to invalidate the whole table at the start of each session.
module cam_route_loader #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int BankSize    = 1
) (
    input logic               clk,
    input logic               rst,
    cam_route_loader_if.slave bus
);
    localparam int CW = AddressSize + 1;
    localparam logic [CW-1:0] FULL = CW'(Words);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   cs_q, cs_d;
    logic                   wr_q, wr_d;
    logic                   flush_q, flush_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic [Bits-1:0]        data_in_q, data_in_d;
    logic [Bits-1:0]        mask_in_q, mask_in_d;
    logic [AddressSize-1:0] addr_in_q, addr_in_d;
    logic [CW-1:0]          count_q, count_d;

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        flush_d    = 1'b0;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        data_in_d  = data_in_q;
        mask_in_d  = mask_in_q;
        addr_in_d  = addr_in_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                count_d    = '0;
                overflow_d = 1'b0;
                busy_d     = 1'b1;
`ifdef ROUTE_LOADER_FLUSH_EN
                state_d    = S_FLUSH;
                cs_d       = 1'b1;
                flush_d    = 1'b1;
`else
                state_d    = S_WAIT;
                ready_d    = 1'b1;
`endif
            end
            S_FLUSH: begin
                state_d = S_WAIT;
                ready_d = 1'b1;
            end
            S_WAIT: if (bus.entry_valid && ready_q) begin
                state_d   = S_WRITE;
                cs_d      = 1'b1;
                wr_d      = 1'b1;
                last_d    = bus.entry_last;
                data_in_d = {bus.entry_src_id, bus.entry_dst_id};
                mask_in_d = {bus.entry_src_mask, {ID_Width{1'b1}}};
                addr_in_d = count_q[AddressSize-1:0];
            end else begin
                ready_d = 1'b1;
            end
            S_WRITE: begin
                count_d = count_q + CW'(1);
                // last wins over a simultaneous table-full, so a full final entry is not an overflow
                if (last_q || count_d == FULL) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    overflow_d = !last_q;
                    data_in_d  = '0;
                    mask_in_d  = '0;
                    addr_in_d  = '0;
                end else begin
                    state_d = S_WAIT;
                    ready_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            flush_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            data_in_q  <= '0;
            mask_in_q  <= '0;
            addr_in_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            flush_q    <= flush_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            data_in_q  <= data_in_d;
            mask_in_q  <= mask_in_d;
            addr_in_q  <= addr_in_d;
            count_q    <= count_d;
        end
    end

    // every write-cycle strobe shares one flop since they always pulse together
    assign bus.entry_ready = ready_q;
    assign bus.CS          = cs_q;
    assign bus.FLUSH       = flush_q;
    assign bus.WR          = wr_q;
    assign bus.VBE         = wr_q;
    assign bus.VBI         = wr_q;
    assign bus.DCS         = wr_q;
    assign bus.CBE         = {BankSize{wr_q}};
    assign bus.Data_In     = data_in_q;
    assign bus.Mask_In     = mask_in_q;
    assign bus.Addr_In     = addr_in_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_cam_route_loader.sv
// tb_cam_route_loader: directed and randomized sessions checked against a write-list model.
module tb_cam_route_loader;
    localparam int IW = 4, AW = 4, BW = 8, WORDS = 16, BK = 1, CW = AW + 1;
`ifdef ROUTE_LOADER_FLUSH_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_route_loader_if #(.ID_Width(IW), .AddressSize(AW), .Bits(BW), .BankSize(BK)) bus();
    cam_route_loader #(.ID_Width(IW), .AddressSize(AW), .Bits(BW), .Words(WORDS), .BankSize(BK))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        logic [BW-1:0] m;
        logic          ok;
    } wr_t;
    wr_t obs[$];
    int flush_n = 0, done_n = 0, flush_bad = 0;

    logic [IW-1:0] src_a[32], dst_a[32], msk_a[32];

    always @(negedge clk) begin
        if (bus.WR)
            obs.push_back('{bus.Addr_In, bus.Data_In, bus.Mask_In,
                            bus.CS && bus.VBE && bus.VBI && bus.DCS && (bus.CBE == '1) && !bus.FLUSH});
        if (bus.FLUSH) begin
            flush_n++;
            if (!bus.CS || bus.WR || bus.VBE || bus.entry_ready) flush_bad++;
        end
        if (bus.done) done_n++;
    end

    task automatic send(input logic [IW-1:0] s, input logic [IW-1:0] m, input logic [IW-1:0] d,
                        input logic l, output bit ok);
        bus.entry_src_id = s;
        bus.entry_src_mask = m;
        bus.entry_dst_id = d;
        bus.entry_last = l;
        bus.entry_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bus.entry_ready;
            @(negedge clk);
        end
        bus.entry_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.busy) begin failures++; $display("FAIL %s_timeout busy=%0b want 0", nm, bus.busy); end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            src_a[i] = IW'($urandom);
            dst_a[i] = IW'($urandom);
            msk_a[i] = IW'($urandom);
        end
    endtask

    // last_at >= WORDS means the session only ends by filling the table
    task automatic run_session(input int n, input int last_at, input string nm);
        int acc = 0;
        int en;
        bit ok, eo;
        wr_t w;
        obs.delete();
        flush_n = 0;
        done_n = 0;
        flush_bad = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send(src_a[i], msk_a[i], dst_a[i], i == last_at, ok);
            acc += int'(ok);
        end
        wait_idle(nm);
        en = (last_at < WORDS) ? last_at + 1 : WORDS;
        eo = !(last_at < WORDS);
        exp_count = en;
        checks++;
        if (acc != en) begin failures++; $display("FAIL %s_accepted got=%0d want=%0d", nm, acc, en); end
        checks++;
        if (obs.size() != en) begin failures++; $display("FAIL %s_writes got=%0d want=%0d", nm, obs.size(), en); end
        for (int k = 0; k < en && k < obs.size(); k++) begin
            w = obs[k];
            checks++;
            if (w.a !== AW'(k) || w.d !== {src_a[k], dst_a[k]} || w.m !== {msk_a[k], 4'hF} || w.ok !== 1'b1) begin
                failures++;
                $display("FAIL %s_write%0d got a=%h d=%h m=%h strobes=%b want a=%h d=%h m=%h strobes=1",
                         nm, k, w.a, w.d, w.m, w.ok, AW'(k), {src_a[k], dst_a[k]}, {msk_a[k], 4'hF});
            end
        end
        checks++;
        if (flush_n != FE || flush_bad != 0) begin
            failures++; $display("FAIL %s_flush got=%0d bad=%0d want=%0d bad=0", nm, flush_n, flush_bad, FE);
        end
        checks++;
        if (done_n != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d want=1", nm, done_n); end
        checks++;
        if (bus.count !== CW'(en)) begin failures++; $display("FAIL %s_count got=%0d want=%0d", nm, bus.count, en); end
        checks++;
        if (bus.overflow !== eo) begin failures++; $display("FAIL %s_overflow got=%b want=%b", nm, bus.overflow, eo); end
        checks++;
        if ({bus.Data_In, bus.Mask_In, bus.Addr_In, bus.entry_ready, bus.done, bus.CS} !== '0) begin
            failures++;
            $display("FAIL %s_idle_outputs got d=%h m=%h a=%h rdy=%b done=%b cs=%b want all 0",
                     nm, bus.Data_In, bus.Mask_In, bus.Addr_In, bus.entry_ready, bus.done, bus.CS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.CS, bus.FLUSH, bus.VBE, bus.DCS, bus.WR, bus.VBI, bus.Data_In, bus.Mask_In, bus.CBE,
             bus.Addr_In, bus.busy, bus.done, bus.overflow, bus.count, bus.entry_ready} !== '0) begin
            failures++; $display("FAIL reset_held outputs not all 0 busy=%b rdy=%b count=%0d", bus.busy, bus.entry_ready, bus.count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.CS, bus.FLUSH, bus.WR, bus.busy, bus.done, bus.overflow, bus.count, bus.entry_ready} !== '0) begin
            failures++; $display("FAIL reset_release busy=%b rdy=%b count=%0d want 0", bus.busy, bus.entry_ready, bus.count);
        end
    endtask

    task automatic test_latency();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (FE == 1) begin
            checks++;
            if (bus.FLUSH !== 1'b1 || bus.CS !== 1'b1 || bus.entry_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++; $display("FAIL lat_flush got flush=%b cs=%b rdy=%b busy=%b want 1 1 0 1", bus.FLUSH, bus.CS, bus.entry_ready, bus.busy);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.entry_ready !== 1'b1 || bus.CS !== 1'b0 || bus.FLUSH !== 1'b0) begin
            failures++; $display("FAIL lat_wait got rdy=%b cs=%b flush=%b want 1 0 0", bus.entry_ready, bus.CS, bus.FLUSH);
        end
        bus.entry_valid = 1'b1;
        bus.entry_src_id = 4'h1; bus.entry_dst_id = 4'h9; bus.entry_src_mask = 4'hF; bus.entry_last = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.WR !== 1'b1 || bus.Addr_In !== 4'h0 || bus.Data_In !== 8'h19 || bus.Mask_In !== 8'hFF || bus.entry_ready !== 1'b0) begin
            failures++; $display("FAIL lat_write1 got wr=%b a=%h d=%h m=%h rdy=%b want 1 0 19 ff 0", bus.WR, bus.Addr_In, bus.Data_In, bus.Mask_In, bus.entry_ready);
        end
        bus.entry_src_id = 4'h2; bus.entry_dst_id = 4'hA; bus.entry_last = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.WR !== 1'b0 || bus.entry_ready !== 1'b1) begin
            failures++; $display("FAIL lat_rewait got wr=%b rdy=%b want 0 1", bus.WR, bus.entry_ready);
        end
        @(negedge clk);
        bus.entry_valid = 1'b0;
        checks++;
        if (bus.WR !== 1'b1 || bus.Addr_In !== 4'h1 || bus.Data_In !== 8'h2A) begin
            failures++; $display("FAIL lat_write2 got wr=%b a=%h d=%h want 1 1 2a", bus.WR, bus.Addr_In, bus.Data_In);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.entry_ready !== 1'b0) begin
            failures++; $display("FAIL lat_done got done=%b busy=%b rdy=%b want 1 1 0", bus.done, bus.busy, bus.entry_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 5'd2 || bus.overflow !== 1'b0) begin
            failures++; $display("FAIL lat_end got busy=%b done=%b count=%0d ovf=%b want 0 0 2 0", bus.busy, bus.done, bus.count, bus.overflow);
        end
    endtask

    task automatic test_basic();
        src_a[0] = 4'h1; src_a[1] = 4'h2; src_a[2] = 4'h3;
        dst_a[0] = 4'h9; dst_a[1] = 4'hA; dst_a[2] = 4'hB;
        msk_a[0] = 4'hF; msk_a[1] = 4'hF; msk_a[2] = 4'hF;
        run_session(3, 2, "basic");
    endtask

    task automatic test_full_last();
        fill_rand(16);
        run_session(16, 15, "full_last");
    endtask

    task automatic test_overflow();
        fill_rand(17);
        run_session(17, 99, "overflow");
    endtask

    task automatic test_mask();
        src_a[0] = 4'h5; dst_a[0] = 4'h3; msk_a[0] = 4'hC;
        run_session(1, 0, "mask");
        checks++;
        if (obs.size() != 1 || obs[0].m !== 8'hCF) begin
            failures++; $display("FAIL mask_cf got n=%0d m=%h want 1 cf", obs.size(), obs.size() ? obs[0].m : 8'h0);
        end
    endtask

    task automatic test_idle_valid();
        bus.entry_valid = 1'b1;
        bus.entry_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.entry_ready !== 1'b0 || bus.busy !== 1'b0 || bus.count !== CW'(exp_count)) begin
                failures++; $display("FAIL idle_valid got rdy=%b busy=%b count=%0d want 0 0 %0d", bus.entry_ready, bus.busy, bus.count, exp_count);
            end
        end
        bus.entry_valid = 1'b0;
    endtask

    task automatic test_busy_start();
        bit ok;
        int k = 0;
        obs.delete();
        flush_n = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send(4'h4, 4'hF, 4'h7, 1'b0, ok);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send(4'h6, 4'hF, 4'h8, 1'b1, ok);
        while (!bus.done && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL busy_start_done got=%b want 1", bus.done); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 5'd2 || flush_n != FE || obs.size() != 2 || bus.entry_ready !== 1'b0) begin
            failures++; $display("FAIL busy_start got busy=%b count=%0d flush=%0d writes=%0d rdy=%b want 0 2 %0d 2 0",
                                 bus.busy, bus.count, flush_n, obs.size(), bus.entry_ready, FE);
        end
        exp_count = 2;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send(4'h1, 4'hF, 4'h2, 1'b0, ok);
        send(4'h3, 4'hF, 4'h4, 1'b0, ok);
        checks++;
        if (bus.WR !== 1'b1 || bus.Addr_In !== 4'h1) begin
            failures++; $display("FAIL rstmid_write got wr=%b a=%h want 1 1", bus.WR, bus.Addr_In);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.CS, bus.WR, bus.VBE, bus.FLUSH, bus.busy, bus.done, bus.entry_ready, bus.count} !== '0) begin
            failures++; $display("FAIL rstmid got cs=%b wr=%b busy=%b rdy=%b count=%0d want all 0", bus.CS, bus.WR, bus.busy, bus.entry_ready, bus.count);
        end
        exp_count = 0;
        test_idle_valid();
    endtask

    task automatic test_random();
        int n, la;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 18);
            la = (n <= WORDS) ? n - 1 : 99;
            fill_rand(n);
            run_session(n, la, "random");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.entry_valid = 1'b0;
        bus.entry_src_id = '0;
        bus.entry_src_mask = '0;
        bus.entry_dst_id = '0;
        bus.entry_last = 1'b0;
        test_reset();
        test_latency();
        test_basic();
        test_full_last();
        test_overflow();
        test_mask();
        test_idle_valid();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
